muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS execute stage, one quotient/product bit per cycle.
- Decodes the R-type funct field for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and owns the architectural HI/LO registers.
- Successor to the combinational ALU decode path: width-parametrised, multi-cycle, with a start/busy/done handshake and a flush.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be ≥4. Counter width is derived as clog2(WIDTH+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request, sampled each edge
- funct  in  6  R-type funct of the issued instruction
- rs_val  in  WIDTH  operand A (dividend / multiplicand / MT source)
- rt_val  in  WIDTH  operand B (divisor / multiplier)
- flush  in  1  synchronous abort of the in-flight operation
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO updated by a MULT/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- mf_result  out  WIDTH  MFHI selects hi, MFLO selects lo, otherwise 0 (combinational from funct)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=lo=0, busy=0, done=0, counter=0, internal operand/accumulator registers=0.
- Funct codes:
  - 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
  - Any other funct with start=1 is ignored: no state change, no done.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, mult/div funct, call this edge E0:
  - Latch operation and signedness.
  - Latch magnitudes: for signed ops the absolute value of each operand; for unsigned ops the raw operand.
  - Record result sign: XOR of operand signs for the quotient/product; dividend sign for the remainder.
  - counter=0; go to RUN.
- RUN:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per edge.
  - counter increments; at the WIDTH-th step edge (E_WIDTH) go to FIX.
- FIX, at edge E_WIDTH+1:
  - Apply sign correction (two's-complement negate where the recorded sign is 1).
  - Write hi/lo. Multiply: hi=upper half, lo=lower half. Divide: lo=quotient, hi=remainder.
  - done=1 for exactly that cycle; go to IDLE.
- Timing:
  - busy=1 on cycles following E0 through E_WIDTH, i.e. WIDTH+1 cycles.
  - busy=0 in the done cycle.
  - Result visible on hi/lo in the same cycle as done.
- MTHI/MTLO with start=1 in IDLE: write rs_val to hi (MTHI) or lo (MTLO) at that edge. Single cycle, no busy, no done.
- Boundary rules:
  - start while busy (RUN/FIX): ignored, including MT*. The pipeline is responsible for stalling.
  - flush=1 in RUN or FIX: return to IDLE at that edge; hi/lo keep their pre-operation values; done stays 0.
    - flush has priority over FIX completion.
    - flush in IDLE has no effect. flush and start on the same IDLE edge: flush wins, nothing issues.
  - Divide by zero (rt_val=0), signed or unsigned: full latency; lo=all ones, hi=rs_val unmodified.
  - Signed overflow, DIV with most-negative value / -1: lo=most-negative value, hi=0, with no trap. This falls out of magnitude arithmetic and must not be special-cased differently.
  - Multiply: the 2·WIDTH product is exact; no overflow exists.
  - Reset asserted mid-operation: immediate return to the reset state; the partial result is discarded.
  - mf_result while busy returns the stale hi/lo. Validity is the pipeline's concern; the unit does not stall MF*.

Decomposition:
- Shared package muldiv_pkg:
  - funct localparams (FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU)
  - state encoding (ST_IDLE, ST_RUN, ST_FIX)
  - op encoding (OP_MUL, OP_DIV)
- One natural sub-module, muldiv_step: combinational single iteration.
  - Inputs: op, accumulator, operand.
  - Output: next accumulator/partial.
  - Instantiated once in muldiv_unit.

Test Plan (WIDTH=32):
- MULTU rs=7, rt=6 → done pulse 33 cycles after the start edge; lo=0x0000002A, hi=0; busy high for exactly 33 cycles.
- MULT rs=0xFFFFFFFD (−3), rt=5 → lo=0xFFFFFFF1, hi=0xFFFFFFFF.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU rs=0x12345678, rt=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI rs=0xAAAA5555 → hi updated next edge with no busy. Then MULTU 3×3 with flush at cycle 10 → busy drops, done never pulses, hi stays 0xAAAA5555.
- MULTU 2×2 started; second start (DIVU) at cycle 5 is ignored → only one done, lo=4. Assert rst_n=0 mid-RUN on a repeat → busy/done/hi/lo all 0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - R-type funct codes handled by the unit
//   - FSM state encoding
//   - operation encoding (multiply / divide)
package muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   op       : OP_MUL = shift-add, OP_DIV = restoring shift-subtract
//   acc      : {upper, lower} accumulator
//              multiply: upper = partial product, lower = remaining multiplier bits
//              divide  : upper = partial remainder, lower = dividend / quotient bits
//   operand  : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   acc_next : accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 op,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        upper    = acc[2*WIDTH-1:WIDTH];
        lower    = acc[WIDTH-1:0];
        // Multiply: add multiplicand when the current multiplier bit is set,
        // carry bit lands in the top of the shifted accumulator.
        add_sum  = {1'b0, upper} + (lower[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Divide: bring in the next dividend bit and trial-subtract.
        // The partial remainder stays below the divisor, so a borrow shows
        // up as bit WIDTH of the difference.
        shifted  = {upper, lower[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = acc;
        if (op == OP_MUL) begin
            acc_next = {add_sum, lower[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_next = {diff[WIDTH-1:0], lower[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {shifted[WIDTH-1:0], lower[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit owning HI/LO.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, funct   : issue request and R-type funct (MULT/MULTU/DIV/DIVU/MT*/MF*)
//   rs_val, rt_val : operands
//   flush          : abort the in-flight operation (HI/LO untouched)
//   busy           : operation in flight (RUN or FIX)
//   done           : one-cycle pulse when HI/LO receive a MULT/DIV result
//   hi, lo         : architectural HI/LO
//   mf_result      : hi for MFHI, lo for MFLO, else 0 (combinational)
// One product/quotient bit per cycle on unsigned magnitudes; signs are
// applied in the FIX state.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic                 is_mul, is_div, is_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_q),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_step)
    );

    // Issue decode and operand magnitudes.
    always_comb begin
        is_mul    = (funct == FN_MULT) || (funct == FN_MULTU);
        is_div    = (funct == FN_DIV)  || (funct == FN_DIVU);
        is_signed = (funct == FN_MULT) || (funct == FN_DIV);
        a_neg     = is_signed & rs_val[WIDTH-1];
        b_neg     = is_signed & rt_val[WIDTH-1];
        mag_a     = a_neg ? -rs_val : rs_val;
        mag_b     = b_neg ? -rt_val : rt_val;
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_fix = q_neg_q ? -acc_q : acc_q;
        quo_fix  = q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = r_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (is_mul || is_div) begin
                        op_d    = is_div ? OP_DIV : OP_MUL;
                        // Divide by zero must yield an all-ones quotient even
                        // for a negative dividend, so its quotient sign is forced
                        // positive. The remainder (= dividend) keeps its sign.
                        q_neg_d = (a_neg ^ b_neg) && !(is_div && (rt_val == '0));
                        r_neg_d = a_neg;
                        acc_d   = is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                        opnd_d  = is_div ? mag_b : mag_a;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else if (funct == FN_MTHI) begin
                        hi_d = rs_val;
                    end else if (funct == FN_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    if (op_q == OP_MUL) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mf_result = (funct == FN_MFHI) ? hi_q :
                       (funct == FN_MFLO) ? lo_q : '0;

endmodule
